// File: rtl/mux_arb_n.sv
// mux_arb_n: registered N-channel multiplexer with valid/ready on every
// input and on the output. It selects by explicit select or by round-robin
// among valid channels, and reports the source channel of each output word.
module mux_arb_n #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  localparam int SW   = ($clog2(NCH) < 1) ? 1 : $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SW-1:0]        s,
  input  logic                 rr_en,
  output logic [WIDTH-1:0]     out_data,
  output logic [SW-1:0]        out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] w_ch_data [NCH];
  logic [NCH-1:0]   w_grant;
  logic [SW-1:0]    w_gidx;
  logic             w_load;
  logic             w_accept;

  logic [WIDTH-1:0] r_out_data;
  logic [SW-1:0]    r_out_ch;
  logic             r_out_valid;
  logic [SW-1:0]    r_ptr;

  // Unpack the flat input bus into per-channel words and form per-channel
  // ready. Ready is forced low while reset is asserted so that no handshake
  // can complete during reset.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign w_ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    assign in_ready[gi]  = w_grant[gi] & w_load & reset_n;
  end

  // The output register may take a word when it is empty or being drained.
  assign w_load   = !r_out_valid || out_ready;
  assign w_accept = w_load && (|w_grant);

  // Grant selection: round-robin searches ptr+1 .. ptr (ptr last), fixed
  // mode grants channel s only if it exists and is valid.
  always_comb begin : p_grant
    int   idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    w_grant = '0;
    w_gidx  = '0;
    if (rr_en) begin
      for (int k = 1; k <= NCH; k++) begin
        idx = (int'(r_ptr) + k) % NCH;
        if (!found && in_valid[idx]) begin
          found        = 1'b1;
          w_grant[idx] = 1'b1;
          w_gidx       = SW'(idx);
        end
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (int'(s) == i && in_valid[i]) begin
          w_grant[i] = 1'b1;
          w_gidx     = SW'(i);
        end
      end
    end
  end

  // Output register and round-robin pointer: capture on accept, clear the
  // valid flag on a drain without refill, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= SW'(NCH - 1);
    end else if (w_accept) begin
      r_out_data  <= w_ch_data[w_gidx];
      r_out_ch    <= w_gidx;
      r_out_valid <= 1'b1;
      r_ptr       <= w_gidx;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule
